// File: rtl/display_pkg.sv
// Shared constants, types and helpers for the count display driver.
package display_pkg;

  localparam int unsigned BIN_W = 8;
  localparam int unsigned NIB_W = 4;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned AN_W  = 4;
  localparam int unsigned DIG_W = 2;
  localparam int unsigned SR_W  = 20;
  localparam int unsigned CNT_W = 3;

  // Digit slot indices in scan order
  localparam logic [DIG_W-1:0] DIG_ONES     = 2'd0;
  localparam logic [DIG_W-1:0] DIG_TENS     = 2'd1;
  localparam logic [DIG_W-1:0] DIG_HUNDREDS = 2'd2;
  localparam logic [DIG_W-1:0] DIG_DIR      = 2'd3;

  // Active-low cathodes {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [SEG_W-1:0] SEG_U     = 7'b1000001;
  localparam logic [SEG_W-1:0] SEG_D     = 7'b0100001;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_e;

  // Non-decimal nibbles render as blank
  function automatic logic [SEG_W-1:0] seg_decode(input logic [NIB_W-1:0] nib);
    logic [SEG_W-1:0] s;
    s = SEG_BLANK;
    if (nib <= 4'd9) s = SEG_DIGIT[nib];
    return s;
  endfunction

  // Double-dabble correction applied before each shift
  function automatic logic [NIB_W-1:0] nib_adj(input logic [NIB_W-1:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 8-bit binary to three BCD digits, reconverting
// whenever the input differs from the last converted value.
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [BIN_W-1:0] bin,
  output logic [NIB_W-1:0] hundreds,
  output logic [NIB_W-1:0] tens,
  output logic [NIB_W-1:0] ones,
  output logic             bcd_valid
);

  conv_state_e      state_q, state_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [SR_W-1:0]  adj_c;
  logic [BIN_W-1:0] cap_q, cap_d;
  logic [BIN_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             force_q, force_d;
  logic [NIB_W-1:0] hun_q, hun_d;
  logic [NIB_W-1:0] ten_q, ten_d;
  logic [NIB_W-1:0] one_q, one_d;
  logic             valid_q, valid_d;

  assign adj_c = {nib_adj(sr_q[19:16]), nib_adj(sr_q[15:12]),
                  nib_adj(sr_q[11:8]), sr_q[7:0]};

  // Conversion FSM next-state; digit outputs only move in DONE so the
  // display never sees a partially converted value.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cap_d   = cap_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    force_d = force_q;
    hun_d   = hun_q;
    ten_d   = ten_q;
    one_d   = one_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (force_q || (bin != last_q)) begin
          sr_d    = SR_W'(bin);
          cap_d   = bin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = {adj_c[SR_W-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(7)) state_d = DONE;
      end
      DONE: begin
        hun_d   = sr_q[19:16];
        ten_d   = sr_q[15:12];
        one_d   = sr_q[11:8];
        last_d  = cap_q;
        force_d = 1'b0;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cap_q   <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      force_q <= 1'b1;
      hun_q   <= '0;
      ten_q   <= '0;
      one_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cap_q   <= cap_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      force_q <= force_d;
      hun_q   <= hun_d;
      ten_q   <= ten_d;
      one_q   <= one_d;
      valid_q <= valid_d;
    end
  end

  assign hundreds  = hun_q;
  assign tens      = ten_q;
  assign ones      = one_q;
  assign bcd_valid = valid_q;

endmodule

// File: rtl/count_display_driver.sv
// 4-digit multiplexed seven-segment driver for the 8-bit counter value.
// Define LEADING_ZERO_BLANK_EN to blank leading zeros on hundreds/tens.
module count_display_driver
  import display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 5000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [BIN_W-1:0] count,
  input  logic             up,
  output logic [SEG_W-1:0] seg,
  output logic [AN_W-1:0]  an,
  output logic             bcd_valid
);

  localparam int unsigned PRE_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [NIB_W-1:0] hundreds, tens, ones;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [DIG_W-1:0] digit_q, digit_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic [AN_W-1:0]  an_q, an_d;
  logic             blank_hun_c, blank_ten_c;

  bin2bcd_seq u_bin2bcd (
    .clk      (clk),
    .reset_n  (reset_n),
    .bin      (count),
    .hundreds (hundreds),
    .tens     (tens),
    .ones     (ones),
    .bcd_valid(bcd_valid)
  );

`ifdef LEADING_ZERO_BLANK_EN
  assign blank_hun_c = (hundreds == '0);
  assign blank_ten_c = blank_hun_c && (tens == '0);
`else
  assign blank_hun_c = 1'b0;
  assign blank_ten_c = 1'b0;
`endif

  // Prescaler/slot advance plus anode and segment selection for the
  // current slot; both register on the same edge so they never disagree.
  always_comb begin
    pre_d   = pre_q + PRE_W'(1);
    digit_d = digit_q;
    if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
      pre_d   = '0;
      digit_d = digit_q + DIG_W'(1);
    end
    an_d  = 4'b1111;
    seg_d = SEG_BLANK;
    case (digit_q)
      DIG_ONES: begin
        an_d  = 4'b1110;
        seg_d = seg_decode(ones);
      end
      DIG_TENS: begin
        an_d  = 4'b1101;
        seg_d = blank_ten_c ? SEG_BLANK : seg_decode(tens);
      end
      DIG_HUNDREDS: begin
        an_d  = 4'b1011;
        seg_d = blank_hun_c ? SEG_BLANK : seg_decode(hundreds);
      end
      DIG_DIR: begin
        an_d  = 4'b0111;
        seg_d = up ? SEG_U : SEG_D;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q   <= '0;
      digit_q <= DIG_ONES;
      an_q    <= 4'b1111;
      seg_q   <= SEG_BLANK;
    end else begin
      pre_q   <= pre_d;
      digit_q <= digit_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_count_display_driver.sv
// Randomized self-checking bench for count_display_driver against a
// behavioural model of conversion latency and scan order.
module tb_count_display_driver;

  localparam int unsigned SD = 4;

  logic       clk;
  logic       reset_n;
  logic [7:0] count;
  logic       up;
  logic [6:0] seg;
  logic [3:0] an;
  logic       bcd_valid;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: edges since release, conversion progress, shown value
  int m_edge, m_rem, m_disp, m_last, m_cap;
  bit m_busy, m_force, m_valid;

  count_display_driver #(.SCAN_DIV(SD)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .count    (count),
    .up       (up),
    .seg      (seg),
    .an       (an),
    .bcd_valid(bcd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", tag, got, exp, m_edge, $time);
    end
  endtask

  function automatic logic [6:0] digit_seg(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] seg_ref(input int d, input int v, input logic u);
    bit blank_h, blank_t;
`ifdef LEADING_ZERO_BLANK_EN
    blank_h = (v < 100);
    blank_t = (v < 10);
`else
    blank_h = 1'b0;
    blank_t = 1'b0;
`endif
    case (d)
      0: return digit_seg(v % 10);
      1: return blank_t ? 7'b1111111 : digit_seg((v / 10) % 10);
      2: return blank_h ? 7'b1111111 : digit_seg(v / 100);
      default: return u ? 7'b1000001 : 7'b0100001;
    endcase
  endfunction

  function automatic void model_reset();
    m_edge  = 0;
    m_rem   = 0;
    m_disp  = 0;
    m_last  = 0;
    m_cap   = 0;
    m_busy  = 1'b0;
    m_force = 1'b1;
    m_valid = 1'b0;
  endfunction

  task automatic check_reset_values();
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_valid", 32'(bcd_valid), 32'h0);
  endtask

  // One clock edge: predict outputs from pre-edge model state, then
  // advance the model; a conversion spans 10 edges from start to result.
  task automatic step();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    int d;
    @(posedge clk);
    m_edge++;
    d = ((m_edge - 1) / SD) % 4;
    e_an = 4'b1111;
    e_an[d] = 1'b0;
    e_seg = seg_ref(d, m_disp, up);
    if (m_busy) begin
      m_rem--;
      if (m_rem == 0) begin
        m_busy  = 1'b0;
        m_disp  = m_cap;
        m_last  = m_cap;
        m_force = 1'b0;
        m_valid = 1'b1;
      end
    end else if (m_force || (int'(count) != m_last)) begin
      m_busy = 1'b1;
      m_rem  = 9;
      m_cap  = int'(count);
    end
    #1;
    check("an", 32'(an), 32'(e_an));
    check("seg", 32'(seg), 32'(e_seg));
    check("bcd_valid", 32'(bcd_valid), 32'(m_valid));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check_reset_values();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset_n = 1'b1;
    count   = 8'd0;
    up      = 1'b1;
    model_reset();
    #2;
    do_reset();

    // Zero after reset, then full-scale value
    run(40);
    count = 8'd255;
    run(40);

    // Small value exercising leading-zero handling
    count = 8'd7;
    run(40);

    // Input changes while a conversion is in flight
    count = 8'd99;
    run(3);
    count = 8'd100;
    run(40);

    // Direction glyph follows up live
    up = 1'b0;
    run(40);
    up = 1'b1;
    run(20);

    // Random values, directions and hold times
    for (int r = 0; r < 30; r++) begin
      count = 8'($urandom_range(0, 255));
      up    = 1'($urandom_range(0, 1));
      run(int'($urandom_range(1, 25)));
    end
    run(20);

    // Reset in the middle of a conversion, then reconvert
    count = 8'd173;
    run(4);
    #2;
    do_reset();
    run(40);

    for (int r = 0; r < 5; r++) begin
      count = 8'($urandom_range(0, 255));
      run(int'($urandom_range(2, 12)));
      #2;
      do_reset();
      run(int'($urandom_range(5, 30)));
    end
    run(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/count_display_driver.md
# count_display_driver

Drives the Basys-class 4-digit multiplexed seven-segment display from the 8-bit up/down counter value. It sits directly downstream of the up/down counter. A sequential double-dabble converter turns the binary count (0–255) into three BCD digits. A scan engine then time-multiplexes hundreds, tens and ones, plus a direction glyph on the fourth digit. It runs in the 5 MHz clock domain produced by the clocking wizard.

## Interface
- SCAN_DIV, default 5000: clk cycles per digit slot; 5000 gives 1 kHz per digit at 5 MHz. Must be ≥ 2.
- clk  input  1  system clock (5 MHz domain)
- reset_n  input  1  asynchronous, active-low reset
- count  input  8  binary counter value; synchronous to clk
- up  input  1  counting direction; 1 = up, 0 = down
- seg  output  7  segment cathodes {g,f,e,d,c,b,a}, active-low
- an  output  4  digit anodes, active-low one-hot; an[0] = ones, an[3] = direction glyph
- bcd_valid  output  1  high once the first conversion after reset has completed; stays high until the next reset

## Operation
- Conversion FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If a force flag is set (set by reset) or count ≠ last_conv, load the 20-bit shift register {12'b0, count}.
  - Capture count into cap, clear the bit counter, and go to SHIFT.
- SHIFT: each cycle, add 3 to every BCD nibble (bits [19:16], [15:12], [11:8]) that is ≥ 5, then shift left by 1. After the 8th shift, go to DONE.
- DONE:
  - Latch the hundreds, tens and ones registers from the shift register.
  - Set last_conv ← cap and clear the force flag.
  - Set bcd_valid ← 1, then return to IDLE.
- If count changes during SHIFT, the in-flight conversion still finishes on cap. IDLE detects the mismatch on the next cycle and starts a new conversion, so no value is ever displayed half-converted.
- Scan prescaler counts 0..SCAN_DIV-1. At terminal count it wraps to 0 and the digit index advances 0→1→2→3→0.
- Digit index to anode and glyph:
  - 0: an = 4'b1110, shows ones.
  - 1: an = 4'b1101, shows tens.
  - 2: an = 4'b1011, shows hundreds.
  - 3: an = 4'b0111, shows the direction glyph.
- Direction glyph: up = 1 shows "U" (7'b1000001); up = 0 shows "d" (7'b0100001). up is sampled live at each slot.
- Digit encoding: 0 = 7'b1000000, 1 = 7'b1111001, …, 9 = 7'b0010000. Nibble values above 9 cannot occur; decode them to blank (7'b1111111).
- While bcd_valid = 0, the digit slots show "0". The BCD registers reset to 0, so no special-casing is needed.

## Timing
- Reset values:
  - FSM in IDLE, force flag = 1, last_conv = 0, cap = 0.
  - BCD registers = 0, bcd_valid = 0.
  - Prescaler = 0, digit index = 0.
  - an = 4'b1111, seg = 7'b1111111.
- seg and an are registered. The first active anode (4'b1110) appears on the first clk edge after reset_n deasserts.
- Conversion latency: count change → new BCD registers = 10 cycles (1 IDLE load + 8 SHIFT + 1 DONE). The new value reaches seg no later than the next slot in which that digit is selected.
- seg and an change on the same edge, so there is no ghosting cycle with mismatched anode and segments.
- Asserting reset_n mid-conversion or mid-slot forces all reset values immediately. After release, a fresh conversion starts at once because the force flag is set.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Hundreds digit is blank when hundreds = 0.
  - Tens digit is blank when hundreds = 0 and tens = 0.
  - Ones digit is always shown.
  - A blank slot keeps its anode active with seg = 7'b1111111.
- LEADING_ZERO_BLANK_EN undefined: all three digits are always shown, e.g. "007".

## Structure
- Package display_pkg holds:
  - Segment constants SEG_DIGIT[0:9], SEG_U, SEG_D, SEG_BLANK.
  - The conversion state enum {IDLE, SHIFT, DONE}.
  - Digit index localparams.
- Sub-module bin2bcd_seq is the natural split. It contains the FSM, the shift register and last_conv. It has ports clk, reset_n, bin[7:0], hundreds/tens/ones[3:0] and bcd_valid. The top holds the prescaler, scan and segment decode.

## Test plan
- Reset, then count = 8'd0, SCAN_DIV = 4 → bcd_valid rises 10 cycles after release; an cycles 1110, 1101, 1011, 0111 every 4 cycles; seg shows "0" on the digit slots (blank on hundreds/tens with the macro defined).
- count = 8'd255, up = 1 → after 10 cycles the ones/tens/hundreds slots show 5/5/2 (7'b0010010, 7'b0010010, 7'b0100100) and slot 3 shows 7'b1000001.
- count = 8'd7 with LEADING_ZERO_BLANK_EN defined → hundreds and tens slots give seg = 7'b1111111; ones slot gives 7'b1111000. Without the macro, "007" is shown.
- count changes 8'd99 → 8'd100 on the 3rd SHIFT cycle → the BCD registers first become 0/9/9, then 1/0/0 after 10 more cycles; "1?9"-style mixing never appears.
- Toggle up 1 → 0 → the next slot-3 period shows 7'b0100001; the digit slots are unaffected.
- Assert reset_n low mid-SHIFT → an = 4'b1111, seg = 7'b1111111 and bcd_valid = 0 immediately; after release, conversion of the current count completes in 10 cycles.
